stack_unit: RTL and testbench
=============================

# stack_unit

Hardware operand stack for the multicycle stack CPU. It is driven directly by the controller's `tos`/`pop`/`push`/`MtoS` strobes and feeds the registered top-of-stack value to the A/B operand registers and the memory address path. It accepts push data either from memory or from the ALU result, and it tracks stack depth with full, empty and error status.

## Interface
- `DEPTH`, 16: number of stack entries; must be a power of two, ≥ 2.
- `WIDTH`, 8: data width of each entry.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tos`  in  1  copy the top entry to `stack_out`; the stack pointer is unchanged.
- `pop`  in  1  copy the top entry to `stack_out` and decrement the stack pointer.
- `push`  in  1  write the selected data at the stack pointer and increment it.
- `MtoS`  in  1  push source select: 1 = `mem_data`, 0 = `alu_data`.
- `mem_data`  in  WIDTH  memory read data.
- `alu_data`  in  WIDTH  ALU result.
- `stack_out`  out  WIDTH  registered top-of-stack value.
- `sp`  out  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
- `empty`  out  1  high when `sp == 0` (combinational from `sp`).
- `full`  out  1  high when `sp == DEPTH` (combinational from `sp`).
- `ovf`  out  1  sticky overflow flag.
- `unf`  out  1  sticky underflow flag.
- `cmd_err`  out  1  sticky flag for an illegal command combination.

## Operation
- Decoded command per cycle: NONE, TOS, POP, PUSH or ILLEGAL. ILLEGAL is any two or more of `tos`/`pop`/`push` high in the same cycle.
- **TOS**, non-empty: `stack_out <= mem[sp-1]`.
- **POP**, non-empty: `stack_out <= mem[sp-1]` and `sp <= sp-1`.
- **PUSH**, not full: `mem[sp] <= MtoS ? mem_data : alu_data` and `sp <= sp+1`. `stack_out` is unchanged.
- **TOS or POP when empty:** no state change except `unf <= 1`.
- **PUSH when full:** the write is dropped, `sp` is unchanged, and `ovf <= 1`.
- **ILLEGAL:** no storage, `sp` or `stack_out` change; `cmd_err <= 1`.
- **NONE:** all state holds. `MtoS` is ignored unless PUSH is decoded.
- Sticky flags clear only on reset.
- Storage contents are not reset and are undefined until written.

## Timing
- Reset values: `sp = 0`, `stack_out = 0`, `ovf = unf = cmd_err = 0`, `empty = 1`, `full = 0`.
- Reset is asynchronous. Asserting it mid-operation immediately drops the stack to empty and abandons any pending write.
- TOS/POP issued in cycle n: `stack_out` and `sp` are valid from cycle n+1. This matches the controller's pop → loadA/loadB sequencing.
- PUSH issued in cycle n: the entry is written at the n edge; a TOS in cycle n+1 returns the pushed value.
- Back-to-back commands are allowed every cycle with no bubbles.
- Storage read is combinational at index `sp-1`; the result is captured into `stack_out` only on TOS/POP.

## Configuration
- Macro: `STACK_BOUNDS_CHECK_EN`.
- **Defined:** full/empty protection as described in Operation; `ovf`/`unf` are live.
- **Undefined:**
  - `sp` is `$clog2(DEPTH)` bits and wraps modulo DEPTH.
  - PUSH on the last entry wraps `sp` to 0 and overwrites the bottom entry.
  - POP at `sp == 0` reads `mem[DEPTH-1]` and wraps `sp` to DEPTH-1.
  - `ovf` and `unf` are tied to 0; `full` is tied to 0.
  - `empty` still reflects `sp == 0`.
  - `cmd_err` behaviour is unchanged.

## Structure
- **Package `stack_pkg`:**
  - `typedef enum logic [2:0] stack_cmd_e {CMD_NONE, CMD_TOS, CMD_POP, CMD_PUSH, CMD_ILLEGAL}`.
  - Default `DEPTH`/`WIDTH` localparams.
  - Function `decode_cmd(tos, pop, push)` returning `stack_cmd_e`.
- **Sub-module `stack_ram`** (DEPTH × WIDTH):
  - Synchronous write with write enable, write address and write data.
  - Asynchronous read port.
  - No reset.
- **`stack_unit`** owns `sp`, `stack_out`, the flags, and the command decode.

## Test plan
- Reset, then PUSH `alu_data=0x11`, then PUSH `mem_data=0x22` with `MtoS=1`, then TOS → `stack_out=0x22`, `sp=2`.
- From `sp=2` holding 0x11/0x22: POP, POP → `stack_out` is 0x22 then 0x11; `sp=0`; `empty=1`; third POP sets `unf=1` with `stack_out` still 0x11.
- Push 17 values 0x01..0x11 with DEPTH=16 and the macro defined → `full=1`, `ovf=1`, `sp=16`; subsequent POP returns 0x10.
- Same stimulus with the macro undefined → `sp=1`, entry 0 = 0x11; TOS returns 0x11; `ovf=0`.
- `tos` and `push` asserted together at `sp=1` → `cmd_err=1`; `sp` and `stack_out` are unchanged.
- Drop `rst` low mid-sequence at `sp=3`, asynchronously between clock edges → `sp=0`, `stack_out=0` and all flags 0 before the next edge.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared types and defaults for the operand stack.
//   stack_cmd_e : decoded per-cycle stack command
//   DEF_DEPTH   : default number of stack entries
//   DEF_WIDTH   : default entry width
//   decode_cmd  : maps the controller's tos/pop/push strobes to a command
package stack_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_TOS,
    CMD_POP,
    CMD_PUSH,
    CMD_ILLEGAL
  } stack_cmd_e;

  // More than one strobe in a cycle has no defined meaning for the
  // controller, so any such combination collapses to ILLEGAL.
  function automatic stack_cmd_e decode_cmd(input logic tos, input logic pop,
                                            input logic push);
    stack_cmd_e cmd;
    case ({tos, pop, push})
      3'b000:  cmd = CMD_NONE;
      3'b100:  cmd = CMD_TOS;
      3'b010:  cmd = CMD_POP;
      3'b001:  cmd = CMD_PUSH;
      default: cmd = CMD_ILLEGAL;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// stack_unit_if: controller-facing bus of the operand stack.
//   master (controller): drives tos/pop/push/MtoS/mem_data/alu_data,
//                        observes stack_out/sp/empty/full/ovf/unf/cmd_err
//   slave  (stack_unit): the reverse directions
// Build option STACK_BOUNDS_CHECK_EN widens sp by one bit so it can hold DEPTH.
interface stack_unit_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
`ifdef STACK_BOUNDS_CHECK_EN
  localparam int SP_W = $clog2(DEPTH) + 1;
`else
  localparam int SP_W = $clog2(DEPTH);
`endif

  logic             tos;
  logic             pop;
  logic             push;
  logic             MtoS;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] alu_data;
  logic [WIDTH-1:0] stack_out;
  logic [SP_W-1:0]  sp;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             cmd_err;

  modport master (
    output tos, pop, push, MtoS, mem_data, alu_data,
    input  stack_out, sp, empty, full, ovf, unf, cmd_err
  );

  modport slave (
    input  tos, pop, push, MtoS, mem_data, alu_data,
    output stack_out, sp, empty, full, ovf, unf, cmd_err
  );

endinterface

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH storage for the operand stack.
//   clk   : write clock
//   we    : write enable (synchronous)
//   waddr : write index
//   wdata : write data
//   raddr : read index (asynchronous read)
//   rdata : read data
// Contents are not reset.
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware operand stack for the multicycle stack CPU.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : stack_unit_if.slave
//         in  tos/pop/push strobes, MtoS push source (1 mem_data, 0 alu_data)
//         out stack_out (registered top of stack), sp (occupancy),
//             empty/full, sticky ovf/unf/cmd_err
// Build option STACK_BOUNDS_CHECK_EN: when defined, sp saturates at 0..DEPTH
// with ovf/unf reporting; when undefined, sp wraps modulo DEPTH, and
// ovf/unf/full read 0.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  stack_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef STACK_BOUNDS_CHECK_EN
  localparam int SP_W = AW + 1;
`else
  localparam int SP_W = AW;
`endif

  stack_cmd_e       cmd;
  logic [SP_W-1:0]  sp_q, sp_nxt, sp_m1;
  logic [WIDTH-1:0] out_q, out_nxt;
  logic             err_q, err_nxt;
  logic             ovf_nxt, unf_nxt;
  logic             we;
  logic [WIDTH-1:0] wdata, rdata;
  logic             is_empty, is_full;

  assign cmd      = decode_cmd(bus.tos, bus.pop, bus.push);
  assign sp_m1    = sp_q - 1'b1;
  assign wdata    = bus.MtoS ? bus.mem_data : bus.alu_data;
  assign is_empty = (sp_q == '0);
`ifdef STACK_BOUNDS_CHECK_EN
  assign is_full  = (sp_q == SP_W'(DEPTH));
`else
  assign is_full  = 1'b0;
`endif

  // The write is qualified with rst so an edge that arrives while reset is
  // held cannot land a pending push in storage.
  stack_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we & rst),
    .waddr (sp_q[AW-1:0]),
    .wdata (wdata),
    .raddr (sp_m1[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    sp_nxt  = sp_q;
    out_nxt = out_q;
    err_nxt = err_q;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    we      = 1'b0;
    case (cmd)
      CMD_TOS, CMD_POP: begin
`ifdef STACK_BOUNDS_CHECK_EN
        if (is_empty) begin
          unf_nxt = 1'b1;
        end else begin
          out_nxt = rdata;
          if (cmd == CMD_POP) sp_nxt = sp_m1;
        end
`else
        // Reading at sp==0 wraps to the last entry.
        out_nxt = rdata;
        if (cmd == CMD_POP) sp_nxt = sp_m1;
`endif
      end
      CMD_PUSH: begin
        if (is_full) begin
          ovf_nxt = 1'b1;
        end else begin
          we     = 1'b1;
          sp_nxt = sp_q + 1'b1;
        end
      end
      CMD_ILLEGAL: err_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_nxt;
      out_q <= out_nxt;
      err_q <= err_nxt;
    end
  end

`ifdef STACK_BOUNDS_CHECK_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_nxt;
      unf_q <= unf_q | unf_nxt;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_nxt | unf_nxt;
  assign bus.ovf = 1'b0;
  assign bus.unf = 1'b0;
`endif

  assign bus.sp        = sp_q;
  assign bus.stack_out = out_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: scoreboard bench for stack_unit (DEPTH=16, WIDTH=8).
// A queue/array reference model computes the expected state after each
// command; a monitor pops expectations and compares against the DUT.
module tb_stack_unit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] so;
    bit         so_known;
    int         sp;
    bit         empty;
    bit         full;
    bit         ovf;
    bit         unf;
    bit         err;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  logic chk_tgl;
  exp_t q[$];
  int   n_vec;
  int   n_err;

  stack_unit_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_mem [DEPTH];
  bit         m_vld [DEPTH];
  int         m_sp;
  logic [7:0] m_out;
  bit         m_known;
  bit         m_ovf, m_unf, m_err;

  task automatic model_reset();
    m_sp = 0; m_out = 8'h00; m_known = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit p, input bit u, input bit ms,
                            input logic [7:0] md, input logic [7:0] ad);
    int n;
    int idx;
    n = int'(t) + int'(p) + int'(u);
    if (n >= 2) begin
      m_err = 1'b1;
    end else if (t || p) begin
`ifdef STACK_BOUNDS_CHECK_EN
      if (m_sp == 0) m_unf = 1'b1;
      else begin
        m_out = m_mem[m_sp-1]; m_known = m_vld[m_sp-1];
        if (p) m_sp = m_sp - 1;
      end
`else
      idx = (m_sp + DEPTH - 1) % DEPTH;
      m_out = m_mem[idx]; m_known = m_vld[idx];
      if (p) m_sp = idx;
`endif
    end else if (u) begin
`ifdef STACK_BOUNDS_CHECK_EN
      if (m_sp == DEPTH) m_ovf = 1'b1;
      else begin
        m_mem[m_sp] = ms ? md : ad; m_vld[m_sp] = 1'b1; m_sp = m_sp + 1;
      end
`else
      m_mem[m_sp] = ms ? md : ad; m_vld[m_sp] = 1'b1;
      m_sp = (m_sp + 1) % DEPTH;
`endif
    end
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.so = m_out; e.so_known = m_known; e.sp = m_sp;
    e.empty = (m_sp == 0);
`ifdef STACK_BOUNDS_CHECK_EN
    e.full = (m_sp == DEPTH);
`else
    e.full = 1'b0;
`endif
    e.ovf = m_ovf; e.unf = m_unf; e.err = m_err; e.nm = nm;
    q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  task automatic issue(input bit t, input bit p, input bit u, input bit ms,
                       input logic [7:0] md, input logic [7:0] ad, input string nm);
    bus.tos = t; bus.pop = p; bus.push = u; bus.MtoS = ms;
    bus.mem_data = md; bus.alu_data = ad;
    model_step(t, p, u, ms, md, ad);
    push_exp(nm);
    @(negedge clk);
  endtask

  // Called at a falling edge: reset lands between edges with a push pending.
  task automatic do_reset(input string nm);
    #2;
    bus.tos = 1'b0; bus.pop = 1'b0; bus.push = 1'b1; bus.MtoS = 1'b0;
    bus.alu_data = 8'($urandom_range(0, 255)); bus.mem_data = 8'hEE;
    rst = 1'b0;
    model_reset();
    push_exp(nm);
    chk_tgl = ~chk_tgl;
    @(negedge clk);
    bus.push = 1'b0;
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input string f, input int act, input int req);
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_tgl);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (e.so_known) cmp(e.nm, "stack_out", int'(bus.stack_out), int'(e.so));
        cmp(e.nm, "sp", int'(bus.sp), e.sp);
        cmp(e.nm, "empty", int'(bus.empty), int'(e.empty));
        cmp(e.nm, "full", int'(bus.full), int'(e.full));
        cmp(e.nm, "ovf", int'(bus.ovf), int'(e.ovf));
        cmp(e.nm, "unf", int'(bus.unf), int'(e.unf));
        cmp(e.nm, "cmd_err", int'(bus.cmd_err), int'(e.err));
      end
    end
  end

  initial begin
    int r;
    logic [7:0] d;
    n_vec = 0; n_err = 0; chk_tgl = 1'b0;
    rst = 1'b0;
    bus.tos = 1'b0; bus.pop = 1'b0; bus.push = 1'b0; bus.MtoS = 1'b0;
    bus.mem_data = '0; bus.alu_data = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_vld[i] = 1'b0; end
    model_reset();

    do_reset("reset0");

    issue(0, 0, 1, 0, 8'h5A, 8'h11, "push_alu");
    issue(0, 0, 1, 1, 8'h22, 8'h99, "push_mem");
    issue(1, 0, 0, 1, 8'h77, 8'h66, "tos");
    issue(0, 1, 0, 0, 8'h00, 8'h00, "pop1");
    issue(0, 1, 0, 0, 8'h00, 8'h00, "pop2");
    issue(0, 1, 0, 0, 8'h00, 8'h00, "pop_empty");
    issue(0, 0, 0, 1, 8'h33, 8'h44, "none_mtos");

    do_reset("reset1");
    for (int i = 1; i <= 17; i++) begin
      d = 8'(i);
      issue(0, 0, 1, i[0], d, d, "fill");
    end
    issue(1, 0, 0, 0, 8'h00, 8'h00, "tos_after_fill");
    issue(0, 1, 0, 0, 8'h00, 8'h00, "pop_after_fill");

    do_reset("reset2");
    issue(0, 0, 1, 0, 8'h00, 8'hA1, "push_a1");
    issue(1, 0, 1, 0, 8'h00, 8'hB2, "illegal_tos_push");
    issue(1, 1, 0, 0, 8'h00, 8'h00, "illegal_tos_pop");
    issue(0, 0, 1, 1, 8'hC3, 8'h00, "push_c3");
    issue(0, 0, 1, 0, 8'h00, 8'hD4, "push_d4");
    do_reset("reset_mid");
    issue(1, 0, 0, 0, 8'h00, 8'h00, "tos_after_reset");

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (i == 200) do_reset("reset_rand");
      if (r < 42)      issue(0, 0, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), "rnd_push");
      else if (r < 64) issue(0, 1, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), "rnd_pop");
      else if (r < 84) issue(1, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), "rnd_tos");
      else if (r < 94) issue(0, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), "rnd_none");
      else             issue(1, 1, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), "rnd_illegal");
    end

    bus.tos = 1'b0; bus.pop = 1'b0; bus.push = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
